fc_layer_mem_responder: RTL and testbench
=========================================

// Module: fc_layer_mem_responder
// PURPOSE
//  Memory-side responder for the fully-connected layer engine. It holds the layer's
//  input vector and weights, answers the engine's address stream with read data,
//  captures its output writes in a result bank, and drives its enable and completion
//  handshake. A host loads the image memory, pulses start, and reads results after done.
// PARAMETERS
//  FRT_CELL  32     front (input) cell count
//  BCK_CELL  20     back (output) cell count
//  TIMEOUT   65535  max RUN cycles before abort; 0 disables the watchdog
//  DEPTH     localparam = 1 + FRT_CELL + FRT_CELL*BCK_CELL image words
// PORTS
//  clk          in   1   clock
//  reset_n      in   1   asynchronous, active-low reset
//  host_we      in   1   host image write strobe
//  host_addr    in   16  host image word address
//  host_wdata   in   16  host image write data
//  start        in   1   one-cycle pulse; begins a layer run
//  res_rd_idx   in   16  result bank read index
//  res_rd_data  out  16  result[res_rd_idx]; combinational, 0 if idx >= BCK_CELL
//  busy         out  1   high in RUN and HOLD
//  done         out  1   one-cycle pulse at run end (normal or aborted)
//  err          out  4   sticky {tmo, host_in_run, short, ovf}; cleared on accepted start
//  layer_enable out  1   enable to the engine
//  layer_rdata  out  16  read data to the engine's input_value
//  layer_addr   in   16  engine address
//  layer_we     in   1   engine write strobe
//  layer_wdata  in   16  engine output value
//  layer_end    in   1   engine layer-complete flag
// BEHAVIOUR
//  Reset: state=IDLE; layer_enable, layer_rdata, busy, done, err, wptr, cycle counter = 0;
//   result bank cleared to 0. Image memory is not reset.
//  Image map: word 0 unused; 1..FRT_CELL = inputs; FRT_CELL+1..DEPTH-1 = weights,
//   row-major (back cell index outer, front cell index inner).
//  FSM IDLE -> RUN -> HOLD -> DONE -> IDLE.
//  IDLE: host_we && host_addr < DEPTH writes mem; writes with host_addr >= DEPTH are
//   dropped. start -> RUN with layer_enable=1, wptr=0, err=0, cycle counter=0.
//  RUN: each cycle layer_rdata <= mem[layer_addr], i.e. one-cycle registered read
//   latency; layer_addr >= DEPTH returns 0. On layer_we: if wptr < BCK_CELL then
//   result[wptr] <= layer_wdata and wptr++; otherwise drop the write and set err.ovf.
//   A host_we in RUN or HOLD is ignored and sets err.host_in_run.
//   layer_end=1 -> HOLD; if wptr != BCK_CELL at that edge, set err.short.
//   Cycle counter increments each RUN cycle. When TIMEOUT != 0 and count == TIMEOUT:
//   set err.tmo -> HOLD.
//  HOLD: layer_enable=0 for exactly one cycle so the engine clears its counters; layer_we
//   is ignored here -> DONE.
//  DONE: done=1 for this one cycle -> IDLE. The result bank holds values until the next start.
//  start outside IDLE is ignored. start and host_we in the same IDLE cycle: the write
//   lands first, then RUN begins.
//  Enable-to-first-useful-read: the engine's own 2-cycle address delay; layer_rdata is
//   valid one cycle after layer_addr.
//  All arithmetic is unsigned 16-bit. Data is opaque: no sign or saturation handling.
// TESTING
//  Load inputs all 0x0100 (1.0) and weights all 0x0080 (0.5), FRT=4, BCK=2; start ->
//   done pulse, err=0, both res_rd_data = 0x0200 and agree with the engine's model.
//  layer_addr sweep 0..DEPTH+2 in RUN -> layer_rdata = mem[a] one cycle later, 0 past DEPTH.
//  Drive BCK_CELL+1 layer_we with values 1..BCK_CELL+1 -> results 1..BCK_CELL, err.ovf=1.
//  Send layer_end after 1 write -> err.short=1, done pulses, layer_enable low one cycle.
//  TIMEOUT=50 with layer_end held low -> RUN exits at cycle 50, err.tmo=1, done=1.
//  Assert reset_n mid-RUN -> enable, busy, err and results = 0 at once; a new start runs cleanly.

Source files
------------

// File: rtl/fc_layer_mem_responder_if.sv
// Engine-side bus between the FC layer engine (master) and its memory responder (slave).
interface fc_layer_mem_responder_if;
    logic        layer_enable;
    logic [15:0] layer_rdata;
    logic [15:0] layer_addr;
    logic        layer_we;
    logic [15:0] layer_wdata;
    logic        layer_end;

    modport master (
        input  layer_enable, layer_rdata,
        output layer_addr, layer_we, layer_wdata, layer_end
    );

    modport slave (
        output layer_enable, layer_rdata,
        input  layer_addr, layer_we, layer_wdata, layer_end
    );
endinterface

// File: rtl/fc_layer_mem_responder.sv
// Memory-side responder for the FC layer engine: holds the input/weight image,
// answers the engine's address stream with registered read data, captures the
// engine's output writes into a result bank and sequences enable/done.
module fc_layer_mem_responder #(
    parameter int FRT_CELL = 32,
    parameter int BCK_CELL = 20,
    parameter int TIMEOUT  = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        host_we,
    input  logic [15:0] host_addr,
    input  logic [15:0] host_wdata,
    input  logic        start,
    input  logic [15:0] res_rd_idx,
    output logic [15:0] res_rd_data,
    output logic        busy,
    output logic        done,
    output logic [3:0]  err,
    fc_layer_mem_responder_if.slave layer
);
    localparam int DEPTH = 1 + FRT_CELL + FRT_CELL * BCK_CELL;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RW    = (BCK_CELL > 1) ? $clog2(BCK_CELL) : 1;

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);
    localparam logic [15:0] BCK_W   = 16'(BCK_CELL);
    localparam logic [15:0] TMO_W   = 16'(TIMEOUT);

    // Sticky error bit positions: {tmo, host_in_run, short, ovf}
    localparam int ERR_OVF   = 0;
    localparam int ERR_SHORT = 1;
    localparam int ERR_HOST  = 2;
    localparam int ERR_TMO   = 3;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_t;

    state_t      state, state_nxt;
    logic [15:0] mem    [DEPTH];
    logic [15:0] result [BCK_CELL];
    logic [15:0] wptr;
    logic [15:0] cycle_cnt;

    logic host_in_img;
    logic rd_in_img;
    logic timeout_hit;

    assign host_in_img = ({1'b0, host_addr} < DEPTH_W);
    assign rd_in_img   = ({1'b0, layer.layer_addr} < DEPTH_W);
    assign timeout_hit = (TIMEOUT != 0) && (cycle_cnt == TMO_W);

    assign busy               = (state == S_RUN) || (state == S_HOLD);
    assign done               = (state == S_DONE);
    assign layer.layer_enable = (state == S_RUN);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state decode: IDLE -> RUN -> HOLD -> DONE -> IDLE.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (layer.layer_end || timeout_hit) state_nxt = S_HOLD;
            S_HOLD:  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Host image load, only while idle; out-of-range writes are dropped.
    // NOTE: the image memory has no reset so it can map onto plain RAM; only the small result bank is cleared.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && host_we && host_in_img)
            mem[host_addr[AW-1:0]] <= host_wdata;
    end

    // Run datapath: registered reads, result capture, counters and sticky errors.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            layer.layer_rdata <= '0;
            wptr              <= '0;
            cycle_cnt         <= '0;
            err               <= '0;
            for (int i = 0; i < BCK_CELL; i++) result[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        wptr      <= '0;
                        cycle_cnt <= '0;
                        err       <= '0;
                    end
                end
                S_RUN: begin
                    layer.layer_rdata <= rd_in_img ? mem[layer.layer_addr[AW-1:0]] : '0;
                    cycle_cnt         <= cycle_cnt + 16'd1;
                    if (layer.layer_we) begin
                        if (wptr < BCK_W) begin
                            result[wptr[RW-1:0]] <= layer.layer_wdata;
                            wptr                 <= wptr + 16'd1;
                        end else begin
                            err[ERR_OVF] <= 1'b1;
                        end
                    end
                    if (layer.layer_end && (wptr != BCK_W)) err[ERR_SHORT] <= 1'b1;
                    if (timeout_hit)                        err[ERR_TMO]   <= 1'b1;
                end
                default: ;
            endcase
            if (busy && host_we) err[ERR_HOST] <= 1'b1;
        end
    end

    // Host result read port; indices past the bank read as zero.
    always_comb begin
        res_rd_data = '0;
        if (res_rd_idx < BCK_W) res_rd_data = result[res_rd_idx[RW-1:0]];
    end
endmodule

// File: tb/tb_fc_layer_mem_responder.sv
// Self-checking bench for fc_layer_mem_responder: the bench plays host and engine,
// pushes expected read data / run errors / result reads into queues, and a
// monitor pops and compares whenever the DUT presents the matching output.
module tb_fc_layer_mem_responder;
    localparam int FRT   = 4;
    localparam int BCK   = 2;
    localparam int TMO   = 50;
    localparam int DEPTH = 1 + FRT + FRT * BCK;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        host_we = 1'b0;
    logic [15:0] host_addr = '0;
    logic [15:0] host_wdata = '0;
    logic        start = 1'b0;
    logic [15:0] res_rd_idx = '0;
    logic [15:0] res_rd_data;
    logic        busy, done;
    logic [3:0]  err;

    fc_layer_mem_responder_if bus ();

    fc_layer_mem_responder #(
        .FRT_CELL(FRT), .BCK_CELL(BCK), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .start(start), .res_rd_idx(res_rd_idx), .res_rd_data(res_rd_data),
        .busy(busy), .done(done), .err(err),
        .layer(bus.slave)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    logic [15:0] img [DEPTH];
    logic [15:0] rd_q  [$];
    logic [15:0] res_q [$];
    logic [3:0]  done_q[$];
    logic        rd_req = 1'b0;
    logic        rd_pipe = 1'b0;
    logic        res_req = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: event with no expectation / bound expired", name);
    endtask

    // Monitor: read data one cycle after a requested address, result reads, done pulses.
    always @(posedge clk) rd_pipe <= rd_req;

    always @(negedge clk) begin
        if (rd_pipe) begin
            if (rd_q.size() > 0) check("layer_rdata", bus.layer_rdata, rd_q.pop_front());
            else                 flag_fail("layer_rdata_underflow");
        end
        if (res_req) begin
            if (res_q.size() > 0) check("res_rd_data", res_rd_data, res_q.pop_front());
            else                  flag_fail("res_underflow");
        end
        if (done) begin
            if (done_q.size() > 0) check("done_err", {12'h000, err}, {12'h000, done_q.pop_front()});
            else                   flag_fail("unexpected_done");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [15:0] a, input logic [15:0] d, input bit idle);
        host_addr  = a;
        host_wdata = d;
        host_we    = 1'b1;
        if (idle && a < DEPTH) img[a] = d;
        tick();
        host_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic engine_read(input logic [15:0] a, output logic [15:0] val);
        bus.layer_addr = a;
        rd_req = 1'b1;
        rd_q.push_back((a < DEPTH) ? img[a] : 16'h0000);
        tick();
        val    = bus.layer_rdata;
        rd_req = 1'b0;
    endtask

    task automatic engine_write(input logic [15:0] d);
        bus.layer_we    = 1'b1;
        bus.layer_wdata = d;
        tick();
        bus.layer_we = 1'b0;
    endtask

    task automatic engine_end();
        bus.layer_end = 1'b1;
        tick();
        bus.layer_end = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) flag_fail("done_timeout");
        tick();
    endtask

    task automatic read_result(input logic [15:0] idx, input logic [15:0] exp);
        res_rd_idx = idx;
        res_req    = 1'b1;
        res_q.push_back(exp);
        tick();
        res_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] x, w, acc, v;
        int run_len;

        bus.layer_addr  = '0;
        bus.layer_we    = 1'b0;
        bus.layer_wdata = '0;
        bus.layer_end   = 1'b0;

        // Reset state
        tick();
        check("rst_busy",   {15'h0, busy}, 16'h0);
        check("rst_done",   {15'h0, done}, 16'h0);
        check("rst_err",    {12'h0, err}, 16'h0);
        check("rst_enable", {15'h0, bus.layer_enable}, 16'h0);
        check("rst_rdata",  bus.layer_rdata, 16'h0);
        check("rst_res0",   res_rd_data, 16'h0);
        tick();
        reset_n = 1'b1;
        tick();

        // Dot product: inputs 1.0, weights 0.5, FRT=4 -> 2.0 per output
        for (int i = 1; i <= FRT; i++) host_write(16'(i), 16'h0100, 1'b1);
        for (int i = FRT + 1; i < DEPTH; i++) host_write(16'(i), 16'h0080, 1'b1);
        pulse_start();
        check("run_busy",   {15'h0, busy}, 16'h1);
        check("run_enable", {15'h0, bus.layer_enable}, 16'h1);
        for (int j = 0; j < BCK; j++) begin
            acc = '0;
            for (int i = 0; i < FRT; i++) begin
                engine_read(16'(1 + i), x);
                engine_read(16'(1 + FRT + j * FRT + i), w);
                acc = acc + 16'((32'(x) * 32'(w)) >> 8);
            end
            engine_write(acc);
        end
        done_q.push_back(4'b0000);
        engine_end();
        wait_done(8);
        read_result(16'd0, 16'h0200);
        read_result(16'd1, 16'h0200);

        // Address sweep; last image write shares its cycle with start
        for (int a = 0; a < DEPTH - 1; a++) host_write(16'(a), 16'(16'h1000 + a * 16'h0111), 1'b1);
        host_addr  = 16'(DEPTH - 1);
        host_wdata = 16'hBEEF;
        host_we    = 1'b1;
        start      = 1'b1;
        img[DEPTH - 1] = 16'hBEEF;
        tick();
        host_we = 1'b0;
        start   = 1'b0;
        host_write(16'd3, 16'hDEAD, 1'b0);
        for (int a = 0; a <= DEPTH + 2; a++) engine_read(16'(a), v);
        done_q.push_back(4'b0110);
        engine_end();
        wait_done(8);

        // Overflow: BCK+1 writes
        pulse_start();
        for (int k = 1; k <= BCK + 1; k++) engine_write(16'(k));
        done_q.push_back(4'b0001);
        engine_end();
        wait_done(8);
        read_result(16'd0, 16'd1);
        read_result(16'd1, 16'd2);
        read_result(16'(BCK), 16'h0000);
        read_result(16'hFFFF, 16'h0000);

        // Short run: end after one write; enable drops for the HOLD cycle
        pulse_start();
        engine_write(16'h0AAA);
        done_q.push_back(4'b0010);
        engine_end();
        check("hold_enable", {15'h0, bus.layer_enable}, 16'h0);
        check("hold_busy",   {15'h0, busy}, 16'h1);
        wait_done(8);
        check("idle_busy",   {15'h0, busy}, 16'h0);
        read_result(16'd0, 16'h0AAA);

        // Watchdog: end never asserted
        pulse_start();
        done_q.push_back(4'b1000);
        run_len = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.layer_enable) break;
            run_len++;
        end
        check("tmo_run_len", 16'(run_len == TMO || run_len == TMO + 1), 16'h1);
        wait_done(8);

        // Reset mid-run, then a clean run
        pulse_start();
        engine_write(16'h1234);
        host_write(16'd1, 16'h5555, 1'b0);
        tick();
        check("pre_rst_err", {12'h0, err}, 16'h0004);
        res_rd_idx = 16'd0;
        reset_n = 1'b0;
        #1;
        check("mid_rst_enable", {15'h0, bus.layer_enable}, 16'h0);
        check("mid_rst_busy",   {15'h0, busy}, 16'h0);
        check("mid_rst_err",    {12'h0, err}, 16'h0);
        check("mid_rst_res0",   res_rd_data, 16'h0);
        tick();
        reset_n = 1'b1;
        tick();
        pulse_start();
        engine_read(16'd2, v);
        engine_write(16'h0011);
        engine_write(16'h0022);
        done_q.push_back(4'b0000);
        engine_end();
        wait_done(8);
        read_result(16'd0, 16'h0011);
        read_result(16'd1, 16'h0022);

        tick();
        if (rd_q.size() != 0 || res_q.size() != 0 || done_q.size() != 0)
            flag_fail("leftover_expectations");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
